// File: rtl/mem_pkg.sv
// Shared encodings for the data memory controller: RISC-V load/store width
// codes, controller state type and the request legality check.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  // True when the width code is legal for this word size and the address is
  // naturally aligned to the access size (low two bits of funct3).
  function automatic logic access_ok(input logic       we,
                                     input logic [2:0] f3,
                                     input logic [2:0] alow,
                                     input logic       wide);
    logic ok;
    ok = 1'b1;
    if (f3 == 3'b111) ok = 1'b0;
    if (we && f3[2]) ok = 1'b0;
    if (!wide && (f3 == F3_LD || f3 == F3_LWU)) ok = 1'b0;
    case (f3[1:0])
      2'd1:    if (alow[0]) ok = 1'b0;
      2'd2:    if (alow[1:0] != 2'b00) ok = 1'b0;
      2'd3:    if (alow != 3'b000) ok = 1'b0;
      default: ;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store strobes and lane placement, load extract and
// sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                   funct3,
  input  logic [$clog2(DATA_W/8)-1:0]  offset,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W-1:0]            rword,
  output logic [DATA_W/8-1:0]          strb,
  output logic [DATA_W-1:0]            wlane,
  output logic [DATA_W-1:0]            rdata
);

  localparam int NB = DATA_W / 8;

  logic [3:0]                nbytes;
  logic [$clog2(DATA_W)-1:0] sh;
  logic [DATA_W-1:0]         shifted;

  // Strobes cover access-size bytes starting at the offset; data is shifted
  // into those lanes so unstrobed lanes never matter.
  always_comb begin
    nbytes = 4'd1 << funct3[1:0];
    sh     = {offset, 3'b000};
    for (int unsigned i = 0; i < NB; i++) begin
      strb[i] = (i >= 32'(offset)) && (i < 32'(offset) + 32'(nbytes));
    end
    wlane   = wdata << sh;
    shifted = rword >> sh;
  end

  // Load result: pick low bytes of the shifted word and extend per width code.
  always_comb begin
    rdata = '0;
    case (funct3)
      F3_LB:   rdata = DATA_W'($signed(shifted[7:0]));
      F3_LH:   rdata = DATA_W'($signed(shifted[15:0]));
      F3_LW:   rdata = DATA_W'($signed(shifted[31:0]));
      F3_LD:   rdata = shifted;
      F3_LBU:  rdata = DATA_W'(shifted[7:0]);
      F3_LHU:  rdata = DATA_W'(shifted[15:0]);
      F3_LWU:  rdata = DATA_W'(shifted[31:0]);
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding load/store controller in front of a byte-writable word
// array, with configurable wait states and a valid/ready response channel.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int DEPTH = (2 ** ADDR_W) / NB;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("data_memory_ctrl: DATA_W must be 32 or 64");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait
    $error("data_memory_ctrl: WAIT_STATES must be 0..7");
  end

  state_t              state;
  logic [2:0]          cnt;
  logic                r_we;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-OFF_W-1:0] widx;
  logic [OFF_W-1:0]    off;
  logic [DATA_W-1:0]   rword;
  logic [NB-1:0]       strb;
  logic [DATA_W-1:0]   wlane;
  logic [DATA_W-1:0]   ext;
  logic                accept;
  logic                last;
  logic                commit;

  assign req_ready = rst_n && (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign accept    = req_valid && req_ready;
  assign widx      = r_addr[ADDR_W-1:OFF_W];
  assign off       = r_addr[OFF_W-1:0];
  assign rword     = mem[widx];
  // Final access cycle: store commits and load data is captured exactly here.
  assign last      = (state == S_ACCESS || state == S_WAIT) && (cnt == 3'd0);
  assign commit    = last && r_we;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3 (r_f3),
    .offset (off),
    .wdata  (r_wdata),
    .rword  (rword),
    .strb   (strb),
    .wlane  (wlane),
    .rdata  (ext)
  );

  // Request/response sequencing; bad requests skip straight to the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_we      <= req_we;
            r_f3      <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            rsp_rdata <= '0;
            if (access_ok(req_we, req_funct3, req_addr[2:0], DATA_W == 64)) begin
              state   <= S_ACCESS;
              cnt     <= 3'(WAIT_STATES);
              rsp_err <= 1'b0;
            end else begin
              state   <= S_RESP;
              rsp_err <= 1'b1;
            end
          end
        end
        S_ACCESS, S_WAIT: begin
          if (cnt == 3'd0) begin
            state     <= S_RESP;
            rsp_rdata <= r_we ? '0 : ext;
          end else begin
            state <= S_WAIT;
            cnt   <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte-enabled storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (strb[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: a 32-bit/3-wait-state instance and a
// 64-bit/0-wait-state instance share one request bus, selected by sel.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [8:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        a_ready, a_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_ready, b_valid, b_err;
  logic [63:0] b_rdata;
  logic        ready, valid, err;
  logic [63:0] rdata;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  logic        exp_active = 1'b0;
  int          exp_acc = 0;
  int          exp_due = 0;
  logic        exp_err = 1'b0;
  logic [63:0] exp_rdata = '0;

  logic [7:0]  mm [2][512];

  always #5 clk = ~clk;

  // Accept-cycle reference for latency checks.
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(3)) d32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_ready(a_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(a_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  data_memory_ctrl #(.ADDR_W(9), .DATA_W(64), .WAIT_STATES(0)) d64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_ready(b_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(b_valid), .rsp_ready(rsp_ready), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  // View of whichever instance is selected.
  always_comb begin
    ready = sel ? b_ready : a_ready;
    valid = sel ? b_valid : a_valid;
    err   = sel ? b_err   : a_err;
    rdata = sel ? b_rdata : {32'h0, a_rdata};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference behaviour: byte-addressed memory, width/sign rules, latency.
  function automatic void model(input logic s, input logic we, input logic [2:0] f3,
                                input int unsigned addr, input logic [63:0] wd,
                                output logic e, output logic [63:0] rd, output int lat);
    int n;
    int dw;
    logic sgn;
    logic [63:0] v;
    dw = s ? 64 : 32;
    n = 0;
    sgn = 1'b0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: begin n = 4; sgn = 1'b1; end
      3'd3: begin n = 8; sgn = 1'b1; end
      3'd4: n = 1;
      3'd5: n = 2;
      3'd6: n = 4;
      default: n = 0;
    endcase
    e = (n == 0) || (we && f3 >= 3'd4) || (dw == 32 && (f3 == 3'd3 || f3 == 3'd6));
    if (!e && (addr % n) != 0) e = 1'b1;
    rd = '0;
    if (e) begin
      lat = 1;
    end else begin
      lat = s ? 2 : 5;
      if (we) begin
        for (int k = 0; k < n; k++) mm[s][addr + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mm[s][addr + k];
        if (sgn && n < 8 && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        if (dw == 32) v[63:32] = '0;
        rd = v;
      end
    end
  endfunction

  // Every cycle of an outstanding request: busy, response timing and held values.
  always @(negedge clk) begin
    if (exp_active && rst_n && cyc >= exp_acc) begin
      chk("req_ready_busy", ready, 1'b0);
      chk("rsp_valid_timing", valid, cyc >= exp_due);
      if (cyc >= exp_due) begin
        chk("rsp_err", err, exp_err);
        chk("rsp_rdata", rdata, exp_rdata);
      end
    end
  end

  task automatic xact(input logic s, input logic we, input logic [2:0] f3,
                      input int unsigned addr, input logic [63:0] wd, input int stall,
                      output logic [63:0] got, output logic gerr);
    logic e;
    logic [63:0] r;
    int lat;
    int n;
    got = '0;
    gerr = 1'b0;
    @(negedge clk);
    sel = s; req_we = we; req_funct3 = f3; req_addr = addr[8:0]; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!ready) begin
      nchk++; nfail++;
      $display("FAIL accept_timeout: got req_ready=0, required 1");
      req_valid = 1'b0;
      return;
    end
    model(s, we, f3, addr, wd, e, r, lat);
    exp_err = e; exp_rdata = r; exp_acc = cyc + 1; exp_due = cyc + lat; exp_active = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid && n < 20) begin @(negedge clk); n++; end
    if (!valid) begin
      nchk++; nfail++;
      $display("FAIL rsp_timeout: got rsp_valid=0, required 1");
      exp_active = 1'b0;
      return;
    end
    got = rdata;
    gerr = err;
    repeat (stall) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] g;
    logic ge;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_a_ready", a_ready, 1'b0);
    chk("reset_a_valid", a_valid, 1'b0);
    chk("reset_a_err", a_err, 1'b0);
    chk("reset_a_rdata", a_rdata, 32'h0);
    chk("reset_b_ready", b_ready, 1'b0);
    chk("reset_b_valid", b_valid, 1'b0);
    chk("reset_b_rdata", b_rdata, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    // 32-bit, three wait states
    xact(1'b0, 1'b1, 3'd2, 32'h10, 64'hDEADBEEF, 0, g, ge);
    xact(1'b0, 1'b0, 3'd2, 32'h10, 64'h0, 0, g, ge);
    chk("lw_10_lit", g, 64'hDEADBEEF);
    chk("lw_10_err_lit", ge, 1'b0);
    xact(1'b0, 1'b1, 3'd0, 32'h13, 64'h7F, 0, g, ge);
    xact(1'b0, 1'b0, 3'd0, 32'h13, 64'h0, 0, g, ge);
    chk("lb_13_lit", g, 64'h7F);
    xact(1'b0, 1'b0, 3'd2, 32'h10, 64'h0, 1, g, ge);
    chk("lw_10_merge_lit", g, 64'h7FADBEEF);
    xact(1'b0, 1'b1, 3'd0, 32'h13, 64'h80, 0, g, ge);
    xact(1'b0, 1'b0, 3'd4, 32'h13, 64'h0, 0, g, ge);
    chk("lbu_13_lit", g, 64'h80);
    xact(1'b0, 1'b0, 3'd0, 32'h13, 64'h0, 0, g, ge);
    chk("lb_13_neg_lit", g, 64'hFFFFFF80);
    xact(1'b0, 1'b0, 3'd1, 32'h11, 64'h0, 2, g, ge);
    chk("lh_11_err_lit", ge, 1'b1);
    chk("lh_11_rdata_lit", g, 64'h0);
    xact(1'b0, 1'b1, 3'd1, 32'h11, 64'hAAAA, 0, g, ge);
    xact(1'b0, 1'b0, 3'd2, 32'h10, 64'h0, 0, g, ge);
    chk("lw_10_untouched_lit", g, 64'h80ADBEEF);
    xact(1'b0, 1'b0, 3'd1, 32'h12, 64'h0, 0, g, ge);
    chk("lh_12_lit", g, 64'hFFFF80AD);
    xact(1'b0, 1'b0, 3'd5, 32'h10, 64'h0, 0, g, ge);
    xact(1'b0, 1'b0, 3'd3, 32'h10, 64'h0, 0, g, ge);
    chk("ld_on_32_err_lit", ge, 1'b1);
    xact(1'b0, 1'b0, 3'd6, 32'h10, 64'h0, 0, g, ge);
    xact(1'b0, 1'b0, 3'd7, 32'h10, 64'h0, 0, g, ge);
    xact(1'b0, 1'b1, 3'd4, 32'h10, 64'h55, 0, g, ge);
    xact(1'b0, 1'b1, 3'd2, 32'h42, 64'h1, 0, g, ge);
    xact(1'b0, 1'b1, 3'd2, 32'h40, 64'hCAFEF00D, 4, g, ge);
    xact(1'b0, 1'b0, 3'd2, 32'h40, 64'h0, 2, g, ge);
    chk("lw_40_stall_lit", g, 64'hCAFEF00D);

    // Reset in the middle of a waiting store
    xact(1'b0, 1'b1, 3'd2, 32'h20, 64'h0, 0, g, ge);
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 9'h20;
    req_wdata = 64'h12345678; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", a_valid, 1'b0);
    chk("midreset_ready", a_ready, 1'b0);
    chk("midreset_err", a_err, 1'b0);
    chk("midreset_rdata", a_rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    xact(1'b0, 1'b0, 3'd2, 32'h20, 64'h0, 0, g, ge);
    chk("lw_20_after_reset_lit", g, 64'h0);

    // 64-bit, no wait states
    xact(1'b1, 1'b1, 3'd3, 32'h8, 64'h0123456789ABCDEF, 0, g, ge);
    xact(1'b1, 1'b0, 3'd6, 32'hC, 64'h0, 0, g, ge);
    chk("lwu_c_lit", g, 64'h0000000001234567);
    xact(1'b1, 1'b0, 3'd2, 32'h8, 64'h0, 0, g, ge);
    chk("lw_8_lit", g, 64'hFFFFFFFF89ABCDEF);
    xact(1'b1, 1'b0, 3'd0, 32'h9, 64'h0, 0, g, ge);
    chk("lb_9_lit", g, 64'hFFFFFFFFFFFFFFCD);
    xact(1'b1, 1'b1, 3'd3, 32'hC, 64'h1, 0, g, ge);
    xact(1'b1, 1'b0, 3'd7, 32'h8, 64'h0, 0, g, ge);
    xact(1'b1, 1'b1, 3'd1, 32'hE, 64'hBEEF, 3, g, ge);
    xact(1'b1, 1'b0, 3'd3, 32'h8, 64'h0, 0, g, ge);
    chk("ld_8_lit", g, 64'hBEEF456789ABCDEF);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
